// File: rtl/mem_stage.sv
// Data-memory pipeline stage: byte-wide RAM with a fixed number of wait states per access.
// Memory ops stall upstream until completion; every completion emits a one-cycle out_valid.
module mem_stage #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_mem_read,
    input  logic       in_mem_write,
    input  logic [3:0] in_reg_write_addr,
    input  logic       in_reg_write_en,
    input  logic       in_mem_to_reg,
    input  logic [7:0] in_alu_out,
    input  logic [7:0] in_store_data,
    input  logic [7:0] in_nextPC,
    output logic       stall,
    output logic       out_valid,
    output logic [3:0] oreg_write_addr,
    output logic [7:0] oreg_write_data,
    output logic       oreg_write_en,
    output logic       omem_to_reg,
    output logic [7:0] oalu_out,
    output logic [7:0] onextPC
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StWait   = 2'd1;
    localparam logic [1:0] StAccess = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Copy of the accepted instruction, held while the access is in flight
    logic       lat_write_q, lat_write_d;
    logic [3:0] lat_waddr_q, lat_waddr_d;
    logic       lat_wen_q, lat_wen_d;
    logic       lat_m2r_q, lat_m2r_d;
    logic [7:0] lat_alu_q, lat_alu_d;
    logic [7:0] lat_sdata_q, lat_sdata_d;
    logic [7:0] lat_npc_q, lat_npc_d;

    logic       valid_q, valid_d;
    logic [3:0] waddr_q, waddr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       wen_q, wen_d;
    logic       m2r_q, m2r_d;
    logic [7:0] alu_q, alu_d;
    logic [7:0] npc_q, npc_d;

    logic [7:0]        mem [0:(1 << ADDR_W) - 1];
    logic [ADDR_W-1:0] addr;
    logic [7:0]        rdata;
    logic              mem_we;

    assign addr   = lat_alu_q[ADDR_W-1:0];
    assign rdata  = mem[addr];
    // A write-flagged op is a store even when the read flag is also set
    assign mem_we = (state_q == StAccess) && lat_write_q && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= lat_sdata_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_write_d = lat_write_q;
        lat_waddr_d = lat_waddr_q;
        lat_wen_d   = lat_wen_q;
        lat_m2r_d   = lat_m2r_q;
        lat_alu_d   = lat_alu_q;
        lat_sdata_d = lat_sdata_q;
        lat_npc_d   = lat_npc_q;
        valid_d     = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wen_d       = wen_q;
        m2r_d       = m2r_q;
        alu_d       = alu_q;
        npc_d       = npc_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (in_mem_read || in_mem_write) begin
                        lat_write_d = in_mem_write;
                        lat_waddr_d = in_reg_write_addr;
                        lat_wen_d   = in_reg_write_en;
                        lat_m2r_d   = in_mem_to_reg;
                        lat_alu_d   = in_alu_out;
                        lat_sdata_d = in_store_data;
                        lat_npc_d   = in_nextPC;
                        cnt_d       = 4'(WAIT_STATES);
                        state_d     = (WAIT_STATES > 0) ? StWait : StAccess;
                    end else begin
                        waddr_d = in_reg_write_addr;
                        wdata_d = in_alu_out;
                        wen_d   = in_reg_write_en;
                        m2r_d   = in_mem_to_reg;
                        alu_d   = in_alu_out;
                        npc_d   = in_nextPC;
                        valid_d = 1'b1;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                waddr_d = lat_waddr_q;
                wdata_d = lat_write_q ? lat_alu_q : rdata;
                wen_d   = lat_wen_q;
                m2r_d   = lat_m2r_q;
                alu_d   = lat_alu_q;
                npc_d   = lat_npc_q;
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            lat_write_q <= 1'b0;
            lat_waddr_q <= 4'd0;
            lat_wen_q   <= 1'b0;
            lat_m2r_q   <= 1'b0;
            lat_alu_q   <= 8'd0;
            lat_sdata_q <= 8'd0;
            lat_npc_q   <= 8'd0;
            valid_q     <= 1'b0;
            waddr_q     <= 4'd0;
            wdata_q     <= 8'd0;
            wen_q       <= 1'b0;
            m2r_q       <= 1'b0;
            alu_q       <= 8'd0;
            npc_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_write_q <= lat_write_d;
            lat_waddr_q <= lat_waddr_d;
            lat_wen_q   <= lat_wen_d;
            lat_m2r_q   <= lat_m2r_d;
            lat_alu_q   <= lat_alu_d;
            lat_sdata_q <= lat_sdata_d;
            lat_npc_q   <= lat_npc_d;
            valid_q     <= valid_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
            m2r_q       <= m2r_d;
            alu_q       <= alu_d;
            npc_q       <= npc_d;
        end
    end

    assign stall           = (state_q != StIdle);
    assign out_valid       = valid_q;
    assign oreg_write_addr = waddr_q;
    assign oreg_write_data = wdata_q;
    assign oreg_write_en   = wen_q;
    assign omem_to_reg     = m2r_q;
    assign oalu_out        = alu_q;
    assign onextPC         = npc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: unit A (ADDR_W=8, 2 wait states) and unit B (ADDR_W=4, no wait states)
// driven from shared inputs, checked against a latency/RAM reference model.
module tb_mem_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_mem_read, in_mem_write, in_reg_write_en, in_mem_to_reg;
    logic [3:0] in_reg_write_addr;
    logic [7:0] in_alu_out, in_store_data, in_nextPC;
    logic       sel;
    logic       valid_a, valid_b;

    logic       a_stall, a_valid, a_wen, a_m2r;
    logic [3:0] a_waddr;
    logic [7:0] a_wdata, a_alu, a_npc;
    logic       b_stall, b_valid, b_wen, b_m2r;
    logic [3:0] b_waddr;
    logic [7:0] b_wdata, b_alu, b_npc;

    int checks = 0;
    int errors = 0;

    // Reference model: RAM image per unit plus which bytes hold a known value
    logic [7:0] mem_m   [2][256];
    bit         known_m [2][256];
    logic [7:0] last_wdata [2];

    always #5 clk = ~clk;

    assign valid_a = in_valid & ~sel;
    assign valid_b = in_valid & sel;

    mem_stage #(.ADDR_W(8), .WAIT_STATES(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(valid_a), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_reg_write_addr(in_reg_write_addr),
        .in_reg_write_en(in_reg_write_en), .in_mem_to_reg(in_mem_to_reg),
        .in_alu_out(in_alu_out), .in_store_data(in_store_data), .in_nextPC(in_nextPC),
        .stall(a_stall), .out_valid(a_valid), .oreg_write_addr(a_waddr),
        .oreg_write_data(a_wdata), .oreg_write_en(a_wen), .omem_to_reg(a_m2r),
        .oalu_out(a_alu), .onextPC(a_npc)
    );

    mem_stage #(.ADDR_W(4), .WAIT_STATES(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(valid_b), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_reg_write_addr(in_reg_write_addr),
        .in_reg_write_en(in_reg_write_en), .in_mem_to_reg(in_mem_to_reg),
        .in_alu_out(in_alu_out), .in_store_data(in_store_data), .in_nextPC(in_nextPC),
        .stall(b_stall), .out_valid(b_valid), .oreg_write_addr(b_waddr),
        .oreg_write_data(b_wdata), .oreg_write_en(b_wen), .omem_to_reg(b_m2r),
        .oalu_out(b_alu), .onextPC(b_npc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        in_valid          = 1'($urandom);
        in_mem_read       = 1'($urandom);
        in_mem_write      = 1'($urandom);
        in_reg_write_addr = 4'($urandom);
        in_reg_write_en   = 1'($urandom);
        in_mem_to_reg     = 1'($urandom);
        in_alu_out        = 8'($urandom);
        in_store_data     = 8'($urandom);
        in_nextPC         = 8'($urandom);
    endtask

    // Issue one instruction to unit s and follow it to completion.
    // With chain set, the caller's next op is presented in the completion cycle.
    task automatic op(input bit s, input bit rd, input bit wr, input logic [3:0] wa,
                      input bit we, input bit m2r, input logic [7:0] alu,
                      input logic [7:0] sd, input logic [7:0] npc, input bit chain);
        int   ws, last, idx;
        bit   is_mem, dknown;
        logic [7:0] exp_data;
        sel = s; in_valid = 1'b1; in_mem_read = rd; in_mem_write = wr;
        in_reg_write_addr = wa; in_reg_write_en = we; in_mem_to_reg = m2r;
        in_alu_out = alu; in_store_data = sd; in_nextPC = npc;
        ws     = s ? 0 : 2;
        is_mem = rd | wr;
        last   = is_mem ? ws + 2 : 1;
        idx    = s ? int'(alu[3:0]) : int'(alu);
        dknown = 1'b1;
        if (wr || !rd) begin
            exp_data = alu;
        end else begin
            exp_data = mem_m[s][idx];
            dknown   = known_m[s][idx];
        end
        if (wr) begin
            mem_m[s][idx]   = sd;
            known_m[s][idx] = 1'b1;
        end
        for (int n = 1; n <= last; n++) begin
            @(posedge clk);
            #1;
            chk("out_valid", s ? b_valid : a_valid, (n == last));
            chk("stall", s ? b_stall : a_stall, (n < last));
            if (n < last) scramble();
        end
        if (dknown) chk("wdata", s ? b_wdata : a_wdata, exp_data);
        chk("waddr", s ? b_waddr : a_waddr, wa);
        chk("wen", s ? b_wen : a_wen, we);
        chk("m2r", s ? b_m2r : a_m2r, m2r);
        chk("alu_out", s ? b_alu : a_alu, alu);
        chk("nextpc", s ? b_npc : a_npc, npc);
        last_wdata[s] = s ? b_wdata : a_wdata;
        if (dknown) last_wdata[s] = exp_data;
        if (!chain) in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("idle_valid_a", a_valid, 1'b0);
            chk("idle_valid_b", b_valid, 1'b0);
            chk("idle_stall", a_stall | b_stall, 1'b0);
            chk("hold_wdata_a", a_wdata, last_wdata[0]);
            chk("hold_wdata_b", b_wdata, last_wdata[1]);
        end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        in_reg_write_addr = 4'd0; in_reg_write_en = 1'b0; in_mem_to_reg = 1'b0;
        in_alu_out = 8'd0; in_store_data = 8'd0; in_nextPC = 8'd0;
        for (int i = 0; i < 256; i++) begin
            known_m[0][i] = 1'b0;
            known_m[1][i] = 1'b0;
            mem_m[0][i]   = 8'd0;
            mem_m[1][i]   = 8'd0;
        end
        last_wdata[0] = 8'd0;
        last_wdata[1] = 8'd0;
        #12;
        chk("rst_stall", a_stall, 1'b0);
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_wdata", a_wdata, 8'd0);
        chk("rst_alu", a_alu, 8'd0);
        chk("rst_npc", a_npc, 8'd0);
        chk("rst_waddr", {a_waddr, a_wen, a_m2r}, 6'd0);
        rst = 1'b0;

        // Store aborted by reset mid-wait must leave the old byte in place
        op(0, 0, 1, 4'd1, 1, 0, 8'h10, 8'h11, 8'h01, 0);
        sel = 1'b0; in_valid = 1'b1; in_mem_read = 1'b0; in_mem_write = 1'b1;
        in_alu_out = 8'h10; in_store_data = 8'hAA;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_abort_stall", a_stall, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_stall", a_stall, 1'b0);
        chk("abort_valid", a_valid, 1'b0);
        chk("abort_wdata", a_wdata, 8'd0);
        chk("abort_alu", a_alu, 8'd0);
        last_wdata[0] = 8'd0;
        last_wdata[1] = 8'd0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        op(0, 1, 0, 4'd2, 1, 1, 8'h10, 8'h00, 8'h02, 0);

        op(0, 0, 0, 4'd5, 1, 0, 8'h3C, 8'h00, 8'h11, 0);
        idle(2);
        op(0, 0, 1, 4'd3, 0, 0, 8'h20, 8'h5A, 8'h21, 1);
        op(0, 1, 0, 4'd4, 1, 1, 8'h20, 8'h00, 8'h22, 0);
        op(1, 0, 1, 4'd6, 0, 0, 8'h07, 8'hC3, 8'h31, 1);
        op(1, 1, 0, 4'd7, 1, 1, 8'h07, 8'h00, 8'h32, 0);
        op(0, 1, 1, 4'd8, 1, 0, 8'h30, 8'h77, 8'h41, 1);
        op(0, 1, 0, 4'd9, 1, 1, 8'h30, 8'h00, 8'h42, 1);
        op(0, 0, 1, 4'd10, 0, 0, 8'hFF, 8'h6E, 8'h43, 1);
        op(0, 1, 0, 4'd11, 1, 1, 8'hFF, 8'h00, 8'h44, 0);
        // Unit B has 16 bytes: 0x35 and 0xF5 alias to the same location
        op(1, 0, 1, 4'd12, 0, 0, 8'h35, 8'h9C, 8'h51, 1);
        op(1, 1, 0, 4'd13, 1, 1, 8'hF5, 8'h00, 8'h52, 0);
        idle(1);

        for (int k = 0; k < 60; k++) begin
            bit         s, rd, wr;
            logic [7:0] a;
            s  = 1'($urandom);
            rd = 1'($urandom);
            wr = 1'($urandom);
            a  = s ? 8'($urandom) : (8'h40 + 8'($urandom_range(0, 7)));
            op(s, rd, wr, 4'($urandom), 1'($urandom), 1'($urandom), a, 8'($urandom),
               8'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
